// File: rtl/br_pkg.sv
// Shared types and constants for the execute-stage branch resolution unit.
// Provides the prediction-queue entry layout, FSM encodings, the sequential
// pc increment and a next-pc helper used for both predicted and actual paths.
package br_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] PC_INC = 32'd4;

  // FSM encoding
  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  // One buffered prediction: fetched pc, predicted direction, predicted target
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            bp_taken;
    logic [XLEN-1:0] bp_pc;
  } pq_entry_t;

  // Next pc for a given direction; the fall-through wraps mod 2^32
  function automatic logic [XLEN-1:0] next_pc(input logic            taken,
                                              input logic [XLEN-1:0] target,
                                              input logic [XLEN-1:0] pc);
    return taken ? target : XLEN'(pc + PC_INC);
  endfunction

endpackage

// File: rtl/br_pred_queue.sv
// In-order prediction queue: synchronous FIFO with push, pop, sync clear and
// a combinational head read. Pointers carry one extra wrap bit so full and
// empty are told apart without an occupancy counter.
// Ports:
//   CLK, RSTN            clock, async active-low reset
//   push, push_data      write one entry (ignored when full)
//   pop                  drop the head entry (ignored when empty)
//   clear                discard all entries; wins over push/pop
//   full, empty          occupancy flags
//   head                 oldest entry (undefined when empty)
module br_pred_queue
  import br_pkg::*;
#(
  parameter int unsigned PQ_DEPTH = 4,
  parameter int unsigned PQ_AW    = 2
) (
  input  logic      CLK,
  input  logic      RSTN,
  input  logic      push,
  input  pq_entry_t push_data,
  input  logic      pop,
  input  logic      clear,
  output logic      full,
  output logic      empty,
  output pq_entry_t head
);

  localparam int unsigned PW = PQ_AW + 1;

  pq_entry_t       mem [PQ_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  // Occupancy flags and guarded push/pop
  always_comb begin
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_ptr[PQ_AW] != rd_ptr[PQ_AW]) &&
              (wr_ptr[PQ_AW-1:0] == rd_ptr[PQ_AW-1:0]);
    do_push = push & ~full & ~clear;
    do_pop  = pop & ~empty & ~clear;
    head    = mem[rd_ptr[PQ_AW-1:0]];
  end

  // Pointer update
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Entry storage; contents are only meaningful behind valid pointers
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr[PQ_AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/branch_resolve.sv
// Execute-stage branch resolution. Buffers each fetched prediction, checks the
// oldest one against the real outcome when an instruction leaves execute, and
// drives the registered predictor update plus a flush/redirect on mismatch.
// Ports:
//   CLK, RSTN                       clock, async active-low reset
//   if_vld/if_pc/if_bp_taken/if_bp_pc  fetched instruction + prediction
//   if_ready                        queue can accept this cycle
//   ex_vld/ex_pc/ex_is_*/ex_taken/ex_target  resolved instruction
//   alu_*                           registered predictor update / flush
//   redirect_pc                     correct next pc, valid with alu_flush
//   branch_cnt, miss_cnt            saturating statistics
//   pq_err                          sticky: resolve seen with empty queue
module branch_resolve
  import br_pkg::*;
#(
  parameter int unsigned PQ_DEPTH  = 4,
  parameter int unsigned PQ_AW     = 2,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RSTN,
  input  logic                 if_vld,
  input  logic [31:0]          if_pc,
  input  logic                 if_bp_taken,
  input  logic [31:0]          if_bp_pc,
  output logic                 if_ready,
  input  logic                 ex_vld,
  input  logic [31:0]          ex_pc,
  input  logic                 ex_is_branch,
  input  logic                 ex_is_call,
  input  logic                 ex_is_return,
  input  logic                 ex_taken,
  input  logic [31:0]          ex_target,
  output logic                 alu_branch,
  output logic                 alu_call,
  output logic                 alu_return,
  output logic                 alu_taken,
  output logic                 alu_flush,
  output logic [31:0]          alu_target,
  output logic [31:0]          alu_pc,
  output logic [31:0]          redirect_pc,
  output logic [CNT_WIDTH-1:0] branch_cnt,
  output logic [CNT_WIDTH-1:0] miss_cnt,
  output logic                 pq_err
);

  logic [0:0]  state_q;
  logic [0:0]  state_d;
  logic        pq_full;
  logic        pq_empty;
  pq_entry_t   pq_head;
  pq_entry_t   pq_wdata;
  logic        pq_push;
  logic        pq_pop;
  logic        ex_accept;
  logic        head_chk;
  logic        mismatch;
  logic [31:0] act_next;
  logic [31:0] pred_next;

  // Head compare and queue control; wrong-path traffic is ignored in FLUSH
  always_comb begin
    ex_accept = ex_vld & (state_q == ST_RUN);
    head_chk  = ex_accept & ~pq_empty;
    act_next  = next_pc(ex_is_branch & ex_taken, ex_target, ex_pc);
    pred_next = next_pc(pq_head.bp_taken, pq_head.bp_pc, pq_head.pc);
    mismatch  = head_chk & ((pq_head.pc != ex_pc) | (pred_next != act_next));
    if_ready  = ~pq_full & (state_q == ST_RUN);
    pq_push   = if_vld & if_ready;
    pq_pop    = head_chk & ~mismatch;
    pq_wdata  = '{pc: if_pc, bp_taken: if_bp_taken, bp_pc: if_bp_pc};
  end

  br_pred_queue #(
    .PQ_DEPTH (PQ_DEPTH),
    .PQ_AW    (PQ_AW)
  ) u_pq (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .push      (pq_push),
    .push_data (pq_wdata),
    .pop       (pq_pop),
    .clear     (mismatch),
    .full      (pq_full),
    .empty     (pq_empty),
    .head      (pq_head)
  );

  // FSM state register
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  // FSM next state: FLUSH lasts exactly one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (mismatch) state_d = ST_FLUSH;
      ST_FLUSH: state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // Registered predictor update; strobes pulse, data fields hold
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      alu_branch  <= 1'b0;
      alu_call    <= 1'b0;
      alu_return  <= 1'b0;
      alu_taken   <= 1'b0;
      alu_flush   <= 1'b0;
      alu_target  <= '0;
      alu_pc      <= '0;
      redirect_pc <= '0;
    end else begin
      alu_branch <= 1'b0;
      alu_call   <= 1'b0;
      alu_return <= 1'b0;
      alu_taken  <= 1'b0;
      alu_flush  <= 1'b0;
      if (ex_accept) begin
        alu_branch  <= ex_is_branch;
        alu_call    <= ex_is_branch & ex_is_call;
        alu_return  <= ex_is_branch & ex_is_return;
        alu_taken   <= ex_is_branch & ex_taken;
        alu_flush   <= mismatch;
        alu_target  <= ex_target;
        alu_pc      <= ex_pc;
        redirect_pc <= act_next;
      end
    end
  end

  // Saturating statistics and sticky underflow flag
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      branch_cnt <= '0;
      miss_cnt   <= '0;
      pq_err     <= 1'b0;
    end else begin
      if (ex_accept && ex_is_branch && (branch_cnt != '1))
        branch_cnt <= branch_cnt + CNT_WIDTH'(1);
      if (mismatch && (miss_cnt != '1))
        miss_cnt <= miss_cnt + CNT_WIDTH'(1);
      if (ex_accept && pq_empty)
        pq_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: stimulus pushes expected alu_*
// updates and status checks into queues; a negedge monitor does all compares.
module tb_branch_resolve;

  logic        CLK;
  logic        RSTN;
  logic        if_vld;
  logic [31:0] if_pc;
  logic        if_bp_taken;
  logic [31:0] if_bp_pc;
  logic        if_ready;
  logic        ex_vld;
  logic [31:0] ex_pc;
  logic        ex_is_branch;
  logic        ex_is_call;
  logic        ex_is_return;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        alu_branch;
  logic        alu_call;
  logic        alu_return;
  logic        alu_taken;
  logic        alu_flush;
  logic [31:0] alu_target;
  logic [31:0] alu_pc;
  logic [31:0] redirect_pc;
  logic [15:0] branch_cnt;
  logic [15:0] miss_cnt;
  logic        pq_err;

  branch_resolve #(.PQ_DEPTH(4), .PQ_AW(2), .CNT_WIDTH(16)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .if_vld(if_vld), .if_pc(if_pc), .if_bp_taken(if_bp_taken), .if_bp_pc(if_bp_pc),
    .if_ready(if_ready),
    .ex_vld(ex_vld), .ex_pc(ex_pc), .ex_is_branch(ex_is_branch), .ex_is_call(ex_is_call),
    .ex_is_return(ex_is_return), .ex_taken(ex_taken), .ex_target(ex_target),
    .alu_branch(alu_branch), .alu_call(alu_call), .alu_return(alu_return),
    .alu_taken(alu_taken), .alu_flush(alu_flush), .alu_target(alu_target),
    .alu_pc(alu_pc), .redirect_pc(redirect_pc),
    .branch_cnt(branch_cnt), .miss_cnt(miss_cnt), .pq_err(pq_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        branch;
    logic        call;
    logic        ret;
    logic        taken;
    logic        flush;
    logic [31:0] target;
    logic [31:0] pc;
    logic [31:0] redirect;
  } upd_t;

  typedef struct {
    int          kind;
    logic [31:0] val;
    string       name;
  } chk_t;

  localparam int K_READY = 0;
  localparam int K_BCNT  = 1;
  localparam int K_MCNT  = 2;
  localparam int K_ERR   = 3;
  localparam int K_STRB  = 4;
  localparam int K_APC   = 5;
  localparam int K_ATGT  = 6;
  localparam int K_RPC   = 7;
  localparam int K_SBQ   = 8;

  upd_t exp_q[$];
  chk_t chk_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [31:0] sample(input int kind);
    case (kind)
      K_READY: return {31'd0, if_ready};
      K_BCNT:  return {16'd0, branch_cnt};
      K_MCNT:  return {16'd0, miss_cnt};
      K_ERR:   return {31'd0, pq_err};
      K_STRB:  return {27'd0, alu_branch, alu_call, alu_return, alu_taken, alu_flush};
      K_APC:   return alu_pc;
      K_ATGT:  return alu_target;
      K_RPC:   return redirect_pc;
      K_SBQ:   return 32'(exp_q.size());
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Monitor: scoreboard on every update/flush strobe, then queued status checks
  always @(negedge CLK) begin
    upd_t        got;
    upd_t        want;
    chk_t        c;
    logic [31:0] act;
    if (RSTN && (alu_branch || alu_flush)) begin
      got = {alu_branch, alu_call, alu_return, alu_taken, alu_flush,
             alu_target, alu_pc, redirect_pc};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_update: got %h, required no strobe", got);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          n_bad++;
          $display("FAIL update: got %h, required %h", got, want);
        end
      end
    end
    while (chk_q.size() > 0) begin
      c   = chk_q.pop_front();
      act = sample(c.kind);
      n_cmp++;
      if (act !== c.val) begin
        n_bad++;
        $display("FAIL %s: got %h, required %h", c.name, act, c.val);
      end
    end
  end

  task automatic cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    if_vld = 0; if_pc = 0; if_bp_taken = 0; if_bp_pc = 0;
    ex_vld = 0; ex_pc = 0; ex_is_branch = 0; ex_is_call = 0;
    ex_is_return = 0; ex_taken = 0; ex_target = 0;
  endtask

  task automatic push_if(input logic [31:0] pc, input logic tk, input logic [31:0] bp);
    if_vld = 1; if_pc = pc; if_bp_taken = tk; if_bp_pc = bp;
  endtask

  task automatic set_ex(input logic [31:0] pc, input logic br, input logic call,
                        input logic ret, input logic tk, input logic [31:0] tgt);
    ex_vld = 1; ex_pc = pc; ex_is_branch = br; ex_is_call = call;
    ex_is_return = ret; ex_taken = tk; ex_target = tgt;
  endtask

  task automatic expect_upd(input logic br, input logic call, input logic ret,
                            input logic tk, input logic fl, input logic [31:0] tgt,
                            input logic [31:0] pc, input logic [31:0] rpc);
    upd_t u;
    u = {br, call, ret, tk, fl, tgt, pc, rpc};
    exp_q.push_back(u);
  endtask

  task automatic check(input int kind, input logic [31:0] val, input string name);
    chk_t c;
    c.kind = kind; c.val = val; c.name = name;
    chk_q.push_back(c);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RSTN = 0;
    idle();
    repeat (2) @(posedge CLK);
    #1 RSTN = 1;
    check(K_READY, 32'd1, "reset_if_ready");
    check(K_BCNT,  32'd0, "reset_branch_cnt");
    check(K_MCNT,  32'd0, "reset_miss_cnt");
    check(K_ERR,   32'd0, "reset_pq_err");
    check(K_STRB,  32'd0, "reset_strobes");
    check(K_APC,   32'd0, "reset_alu_pc");
    check(K_RPC,   32'd0, "reset_redirect");

    // Correctly predicted taken branch
    push_if(32'h100, 1, 32'h200); cycle();
    idle(); set_ex(32'h100, 1, 0, 0, 1, 32'h200);
    expect_upd(1, 0, 0, 1, 0, 32'h200, 32'h100, 32'h200);
    cycle(); idle();
    check(K_BCNT, 32'd1, "t1_branch_cnt");
    cycle();
    check(K_STRB, 32'd0, "t1_strobe_pulse");

    // Direction miss; younger entry and same-cycle push discarded
    push_if(32'h100, 0, 32'h0); cycle();
    push_if(32'h104, 0, 32'h0); cycle();
    idle(); push_if(32'h108, 0, 32'h0); set_ex(32'h100, 1, 0, 0, 1, 32'h180);
    expect_upd(1, 0, 0, 1, 1, 32'h180, 32'h100, 32'h180);
    cycle(); idle();
    check(K_READY, 32'd0, "t2_ready_in_flush");
    check(K_MCNT,  32'd1, "t2_miss_cnt");
    check(K_BCNT,  32'd2, "t2_branch_cnt");
    cycle();
    check(K_READY, 32'd1, "t2_ready_after_flush");
    push_if(32'h500, 0, 32'h0); cycle();
    idle(); set_ex(32'h500, 0, 0, 0, 0, 32'h0); cycle(); idle();
    check(K_MCNT, 32'd1, "t2_queue_discarded");
    check(K_STRB, 32'd0, "t2_nonbranch_strobes");

    // Return with wrong predicted target
    push_if(32'h300, 1, 32'h400); cycle();
    idle(); set_ex(32'h300, 1, 0, 1, 1, 32'h404);
    expect_upd(1, 0, 1, 1, 1, 32'h404, 32'h300, 32'h404);
    cycle(); idle();
    check(K_MCNT, 32'd2, "t3_miss_cnt");
    cycle();
    check(K_BCNT, 32'd3, "t3_branch_cnt");

    // Fill queue, reject fifth, drain in order
    for (int i = 0; i < 4; i++) begin
      push_if(32'h1000 + 32'(4 * i), 0, 32'h0); cycle();
    end
    idle();
    check(K_READY, 32'd0, "t4_full_ready");
    push_if(32'h1010, 0, 32'h0); cycle(); idle();
    check(K_READY, 32'd0, "t4_fifth_rejected_ready");
    set_ex(32'h1000, 0, 0, 0, 0, 32'h0); cycle(); idle();
    check(K_READY, 32'd1, "t4_ready_after_pop");
    for (int i = 1; i < 4; i++) begin
      set_ex(32'h1000 + 32'(4 * i), 1, 0, 0, 0, 32'h2000);
      expect_upd(1, 0, 0, 0, 0, 32'h2000, 32'h1000 + 32'(4 * i), 32'h1004 + 32'(4 * i));
      cycle();
    end
    idle();
    check(K_BCNT, 32'd6, "t4_branch_cnt");

    // pc+4 wrap on a non-branch (call flag must not leak out)
    push_if(32'hFFFF_FFFC, 0, 32'h0); cycle();
    idle(); set_ex(32'hFFFF_FFFC, 0, 1, 0, 0, 32'h1234); cycle(); idle();
    check(K_STRB, 32'd0, "t5_nonbranch_strobes");
    check(K_APC,  32'hFFFF_FFFC, "t5_alu_pc");
    check(K_ATGT, 32'h1234, "t5_alu_target");
    check(K_RPC,  32'h0, "t5_wrap_redirect");
    check(K_MCNT, 32'd2, "t5_no_flush");
    check(K_ERR,  32'd0, "t5_no_err");

    // Resolve on empty queue with simultaneous push
    set_ex(32'h700, 1, 0, 0, 1, 32'h800); push_if(32'h900, 1, 32'hA00);
    expect_upd(1, 0, 0, 1, 0, 32'h800, 32'h700, 32'h800);
    cycle(); idle();
    check(K_ERR,  32'd1, "t5_empty_err");
    check(K_BCNT, 32'd7, "t5_branch_cnt");
    cycle();
    check(K_ERR, 32'd1, "t5_err_sticky");
    set_ex(32'h900, 1, 0, 0, 1, 32'hA00);
    expect_upd(1, 0, 0, 1, 0, 32'hA00, 32'h900, 32'hA00);
    cycle(); idle();
    check(K_BCNT, 32'd8, "t5_pushed_entry");

    // pc mismatch flush; wrong-path traffic during FLUSH ignored
    push_if(32'hB00, 0, 32'h0); cycle();
    idle(); set_ex(32'hB08, 0, 0, 0, 0, 32'h0); push_if(32'hC00, 0, 32'h0);
    expect_upd(0, 0, 0, 0, 1, 32'h0, 32'hB08, 32'hB0C);
    cycle();
    check(K_MCNT,  32'd3, "t6_miss_cnt");
    check(K_READY, 32'd0, "t6_ready_in_flush");
    push_if(32'hC04, 0, 32'h0); set_ex(32'hC00, 1, 0, 0, 1, 32'hD00);
    cycle(); idle();
    check(K_BCNT,  32'd8, "t6_flush_ex_ignored");
    check(K_READY, 32'd1, "t6_ready_back");
    push_if(32'hE00, 0, 32'h0); cycle();
    idle(); set_ex(32'hE00, 0, 0, 0, 0, 32'h0); cycle(); idle();
    check(K_MCNT, 32'd3, "t6_pushes_dropped");

    // Asynchronous reset mid-operation
    push_if(32'h40, 0, 32'h0); cycle(); idle();
    #2 RSTN = 0;
    check(K_BCNT,  32'd0, "rst_branch_cnt");
    check(K_MCNT,  32'd0, "rst_miss_cnt");
    check(K_ERR,   32'd0, "rst_pq_err");
    check(K_READY, 32'd1, "rst_if_ready");
    check(K_APC,   32'd0, "rst_alu_pc");
    @(negedge CLK);
    #1 RSTN = 1;
    cycle();
    set_ex(32'h40, 0, 0, 0, 0, 32'h0); cycle(); idle();
    check(K_ERR,  32'd1, "rst_queue_cleared");
    check(K_STRB, 32'd0, "rst_no_strobe");

    cycle(); cycle();
    check(K_SBQ, 32'd0, "scoreboard_drained");
    cycle(); cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
